fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the async_fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // Index/select widths never collapse to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping around.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin : pick
    int  cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the async_fifo write port.
// Optional statistics counters are enabled with FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW       = clog2_min1(NUM_REQ)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  input  logic [NUM_REQ-1:0]       last,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_datain,
  input  logic                     fifo_full,
  output logic [OW-1:0]            owner,
  output logic                     busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic [OW-1:0]            stat_sel,
  input  logic                     stat_clr,
  output logic [STAT_W-1:0]        stat_cnt,
  output logic [STAT_W-1:0]        stat_stall
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_t               state;
  logic [OW-1:0]        rr_ptr;
  logic [OW-1:0]        pick_idx;
  logic [OW-1:0]        nxt_ptr;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [BW-1:0]        beat_cnt;
  logic                 in_burst;
  logic                 own_req;
  logic                 accept;
  logic                 burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  assign in_burst    = (state == BURST);
  assign own_req     = req[owner];
  assign accept      = in_burst & own_req & ~fifo_full;
  // A withdrawn request ends the burst without taking a word.
  assign burst_end   = in_burst & (~own_req |
                       (accept & (last[owner] | (beat_cnt == BW'(MAX_BURST - 1)))));
  assign nxt_ptr     = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign fifo_push   = accept;
  assign fifo_datain = data[int'(owner)*WIDTH +: WIDTH];

  always_comb begin
    ack = '0;
    if (accept) ack[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick_grant) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (burst_end) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] acc_cnt [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) acc_cnt[owner] <= sat_inc(acc_cnt[owner]);
      if (in_burst && own_req && fifo_full) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stat_cnt   = (int'(stat_sel) < NUM_REQ) ? acc_cnt[stat_sel] : '0;
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter with a packet-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, last, ack;
  logic [N*W-1:0] data;
  logic           fifo_push, fifo_full, busy;
  logic [W-1:0]   fifo_datain;
  logic [1:0]     owner;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [1:0]     stat_sel;
  logic           stat_clr;
  logic [15:0]    stat_cnt, stat_stall;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last), .ack(ack),
    .fifo_push(fifo_push), .fifo_datain(fifo_datain), .fifo_full(fifo_full),
    .owner(owner), .busy(busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Producers: rem = words left in the current packet (0 = not requesting).
  int         rem [N];
  logic [W-1:0] word [N];
  int         cnt_acc [N];
  int         stall_n;
  logic       clr_in;

  // Reference arbitration state.
  bit  m_busy;
  int  m_owner, m_ptr, m_words;

  bit  e_acc, e_busy, e_stall;
  int  e_owner;
  logic [W-1:0] e_data;
  logic [N-1:0] s_ack;
  logic         s_push, s_busy, s_last;
  logic [W-1:0] s_data;
  logic [1:0]   s_owner;
  int           q_own[$];
  logic         q_last[$];
  logic [W-1:0] q_data[$];
  logic [W-1:0] q_exp[$];

  function automatic void apply_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]         = (rem[i] > 0);
      last[i]        = (rem[i] == 1);
      data[i*W +: W] = word[i];
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    e_acc   = m_busy && req[m_owner] && !fifo_full;
    e_stall = m_busy && req[m_owner] && fifo_full;
    e_owner = m_owner;
    e_busy  = m_busy;
    e_data  = word[m_owner];
    s_ack = ack; s_push = fifo_push; s_data = fifo_datain;
    s_owner = owner; s_busy = busy; s_last = last[m_owner];
    if (fifo_push === 1'b1) begin
      q_own.push_back(int'(owner));
      q_last.push_back(last[owner]);
      q_data.push_back(fifo_datain);
      q_exp.push_back(word[owner]);
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_words = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_busy = 1; m_words = 0;
        end
      end
    end else if (!req[m_owner] ||
                 (e_acc && (last[m_owner] || m_words + 1 == MB))) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end else if (e_acc) begin
      m_words++;
    end
    if (rst || clr_in) begin
      for (int i = 0; i < N; i++) cnt_acc[i] = 0;
      stall_n = 0;
    end else begin
      if (e_acc) cnt_acc[e_owner]++;
      if (e_stall) stall_n++;
    end
    if (e_acc) begin
      word[e_owner] = word[e_owner] + 1'b1;
      rem[e_owner]--;
    end
    #1;
    apply_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_full = 1'b0; clr_in = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) rem[i] = 0;
    apply_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && guard < 200) begin
      tick(); guard++;
    end
    checks++;
    if (guard >= 200) $display("FAIL drain timeout: words left %0d, required 0", rem[0]+rem[1]+rem[2]+rem[3]);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_full = 1'b0; clr_in = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; word[i] = W'(i * 32); end
    apply_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", s_busy); else passed++;
    checks++; if (s_push !== 1'b0) $display("FAIL reset_push: got %b, required 0", s_push); else passed++;
    checks++; if (s_ack !== 4'b0) $display("FAIL reset_ack: got %b, required 0000", s_ack); else passed++;
    checks++; if (s_owner !== 2'd0) $display("FAIL reset_owner: got %0d, required 0", s_owner); else passed++;
    // Reset in the middle of requester 2's burst.
    rem[2] = 4; apply_inputs();
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rem[0] = 1; apply_inputs();
    tick();
    checks++; if (s_busy !== 1'b0) $display("FAIL midreset_busy: got %b, required 0", s_busy); else passed++;
    tick();
    checks++; if (s_owner !== 2'd0 || s_push !== 1'b1)
      $display("FAIL midreset_regrant: owner %0d push %b, required owner 0 push 1", s_owner, s_push);
    else passed++;
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_sel = 2'd1;
`endif
    for (int i = 0; i < N; i++) rem[i] = 6;
    apply_inputs();
    q_own.delete(); q_last.delete(); q_data.delete(); q_exp.delete();
    repeat (20) tick();
    checks++; if (q_own.size() != 16) $display("FAIL rr_pushcount: got %0d, required 16", q_own.size()); else passed++;
    for (int k = 0; k < 16 && k < q_own.size(); k++) begin
      checks++;
      if (q_own[k] != k / 4 || q_last[k] !== 1'b0 || q_data[k] !== q_exp[k])
        $display("FAIL rr_word%0d: owner %0d last %b data %h, required owner %0d last 0 data %h",
                 k, q_own[k], q_last[k], q_data[k], k / 4, q_exp[k]);
      else passed++;
    end
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stat_cnt !== 16'd4) $display("FAIL rr_stat_cnt: got %0d, required 4", stat_cnt); else passed++;
    stat_clr = 1'b1; clr_in = 1'b1; tick(); stat_clr = 1'b0; clr_in = 1'b0;
    checks++; if (stat_cnt !== 16'd0 || stat_stall !== 16'd0)
      $display("FAIL rr_stat_clr: cnt %0d stall %0d, required 0 0", stat_cnt, stat_stall);
    else passed++;
`endif
    drain();
  endtask

  task automatic test_packet_end();
    do_reset();
    rem[1] = 2; rem[3] = 5; apply_inputs();
    q_own.delete(); q_last.delete(); q_data.delete(); q_exp.delete();
    repeat (5) tick();
    checks++;
    if (q_own.size() != 3) $display("FAIL pkt_count: got %0d pushes, required 3", q_own.size());
    else if (q_own[0] != 1 || q_own[1] != 1 || q_own[2] != 3 || q_last[1] !== 1'b1)
      $display("FAIL pkt_order: got %0d,%0d,%0d last %b, required 1,1,3 last 1", q_own[0], q_own[1], q_own[2], q_last[1]);
    else passed++;
    drain();
  endtask

  task automatic test_full_stall();
    do_reset();
    rem[0] = 6; apply_inputs();
    q_own.delete(); q_last.delete(); q_data.delete(); q_exp.delete();
    tick(); tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (s_push !== 1'b0 || s_owner !== 2'd0 || s_busy !== 1'b1)
        $display("FAIL stall_c%0d: push %b owner %0d busy %b, required 0 0 1", c, s_push, s_owner, s_busy);
      else passed++;
    end
    fifo_full = 1'b0;
    tick(); tick(); tick();
    checks++; if (q_own.size() != 4) $display("FAIL stall_total: got %0d words, required 4", q_own.size()); else passed++;
    tick();
    checks++; if (s_busy !== 1'b0 || s_push !== 1'b0)
      $display("FAIL stall_gap: busy %b push %b, required 0 0", s_busy, s_push);
    else passed++;
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stat_stall !== 16'd5) $display("FAIL stat_stall: got %0d, required 5", stat_stall); else passed++;
`endif
    drain();
  endtask

  task automatic test_withdraw();
    do_reset();
    rem[2] = 3; rem[3] = 2; apply_inputs();
    tick(); tick();
    rem[2] = 0; apply_inputs();
    tick();
    checks++; if (s_push !== 1'b0 || s_ack !== 4'b0 || s_owner !== 2'd2)
      $display("FAIL withdraw_exit: push %b ack %b owner %0d, required 0 0000 2", s_push, s_ack, s_owner);
    else passed++;
    tick();
    checks++; if (s_busy !== 1'b0) $display("FAIL withdraw_gap: busy %b, required 0", s_busy); else passed++;
    tick();
    checks++; if (s_owner !== 2'd3 || s_push !== 1'b1 || s_ack !== 4'b1000)
      $display("FAIL withdraw_next: owner %0d push %b ack %b, required 3 1 1000", s_owner, s_push, s_ack);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ack;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fifo_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 6);
          word[i] = W'($urandom);
        end else if (rem[i] > 0 && $urandom_range(0, 60) == 0) begin
          rem[i] = 0;
        end
      end
      apply_inputs();
      tick();
      exp_ack = e_acc ? (4'b0001 << e_owner) : 4'b0000;
      checks++;
      if (s_ack !== exp_ack || s_push !== e_acc || s_busy !== e_busy || s_owner !== 2'(e_owner))
        $display("FAIL rand_c%0d: ack %b push %b busy %b owner %0d, required %b %b %b %0d",
                 c, s_ack, s_push, s_busy, s_owner, exp_ack, e_acc, e_busy, e_owner);
      else passed++;
      if (e_acc) begin
        checks++;
        if (s_data !== e_data) $display("FAIL rand_data_c%0d: got %h, required %h", c, s_data, e_data);
        else passed++;
      end
    end
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stat_stall !== 16'(stall_n)) $display("FAIL rand_stall: got %0d, required %0d", stat_stall, stall_n); else passed++;
    for (int i = 0; i < N; i++) begin
      stat_sel = 2'(i); #1;
      checks++; if (stat_cnt !== 16'(cnt_acc[i])) $display("FAIL rand_cnt%0d: got %0d, required %0d", i, stat_cnt, cnt_acc[i]); else passed++;
    end
`endif
    fifo_full = 1'b0;
    drain();
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_ptr = 0; m_words = 0; stall_n = 0;
    for (int i = 0; i < N; i++) cnt_acc[i] = 0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_sel = 2'd0; stat_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_packet_end();
    test_full_stall();
    test_withdraw();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
